// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, load/store and memory-side signals around mem_port_arbiter.
// slave = arbiter view, master = requesters plus memory slave view.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned BE_W = DATA_W / 8;

  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic              if_gnt_o;
  logic              if_rvalid_o;
  logic [DATA_W-1:0] if_rdata_o;
  logic              if_err_o;

  logic              ls_req_i;
  logic              ls_we_i;
  logic [BE_W-1:0]   ls_be_i;
  logic [ADDR_W-1:0] ls_addr_i;
  logic [DATA_W-1:0] ls_wdata_i;
  logic              ls_gnt_o;
  logic              ls_rvalid_o;
  logic [DATA_W-1:0] ls_rdata_o;
  logic              ls_err_o;

  logic              mem_req_o;
  logic              mem_we_o;
  logic [BE_W-1:0]   mem_be_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic              mem_gnt_i;
  logic              mem_rvalid_i;
  logic [DATA_W-1:0] mem_rdata_i;

  modport slave (
    input  if_req_i, if_addr_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o, if_err_o,
    input  ls_req_i, ls_we_i, ls_be_i, ls_addr_i, ls_wdata_i,
    output ls_gnt_o, ls_rvalid_o, ls_rdata_o, ls_err_o,
    output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );

  modport master (
    output if_req_i, if_addr_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o, if_err_o,
    output ls_req_i, ls_we_i, ls_be_i, ls_addr_i, ls_wdata_i,
    input  ls_gnt_o, ls_rvalid_o, ls_rdata_o, ls_err_o,
    input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and load/store, one transaction in flight.
// Define ARB_ROUND_ROBIN_EN for round-robin tie breaking; default is fixed LS > IF.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic clk_i,
  input  logic rst_i,
  mem_port_arbiter_if.slave bus
);
  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned CNT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_owner_ls;
  logic              r_we;
  logic [BE_W-1:0]   r_be;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_mem_req;
  logic              r_if_rvalid;
  logic              r_if_err;
  logic [DATA_W-1:0] r_if_rdata;
  logic              r_ls_rvalid;
  logic              r_ls_err;
  logic [DATA_W-1:0] r_ls_rdata;
`ifdef ARB_ROUND_ROBIN_EN
  logic              r_last_ls;
`endif

  logic w_idle;
  logic w_pick_ls;
  logic w_if_gnt;
  logic w_ls_gnt;
  logic w_timeout;

  // Arbitration: grants are only ever issued while idle and out of reset.
  always_comb begin
    w_idle    = (r_state == ST_IDLE) && !rst_i;
`ifdef ARB_ROUND_ROBIN_EN
    w_pick_ls = bus.ls_req_i && (!bus.if_req_i || !r_last_ls);
`else
    w_pick_ls = bus.ls_req_i;
`endif
    w_ls_gnt  = w_idle && w_pick_ls;
    w_if_gnt  = w_idle && bus.if_req_i && !w_pick_ls;
    w_timeout = (MAX_WAIT != 0) && (r_cnt == CNT_W'(MAX_WAIT));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= ST_IDLE;
      r_owner_ls  <= 1'b0;
      r_we        <= 1'b0;
      r_be        <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cnt       <= '0;
      r_mem_req   <= 1'b0;
      r_if_rvalid <= 1'b0;
      r_if_err    <= 1'b0;
      r_if_rdata  <= '0;
      r_ls_rvalid <= 1'b0;
      r_ls_err    <= 1'b0;
      r_ls_rdata  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      r_last_ls   <= 1'b0;
`endif
    end else begin
      r_if_rvalid <= 1'b0;
      r_if_err    <= 1'b0;
      r_ls_rvalid <= 1'b0;
      r_ls_err    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_ls_gnt || w_if_gnt) begin
            r_owner_ls <= w_ls_gnt;
            r_we       <= w_ls_gnt && bus.ls_we_i;
            r_be       <= w_ls_gnt ? bus.ls_be_i : '1;
            r_addr     <= w_ls_gnt ? bus.ls_addr_i : bus.if_addr_i;
            r_wdata    <= w_ls_gnt ? bus.ls_wdata_i : '0;
            r_mem_req  <= 1'b1;
            r_state    <= ST_REQ;
`ifdef ARB_ROUND_ROBIN_EN
            r_last_ls  <= w_ls_gnt;
`endif
          end
        end
        ST_REQ: begin
          if (bus.mem_gnt_i) begin
            r_mem_req <= 1'b0;
            r_cnt     <= '0;
            r_state   <= ST_RESP;
          end
        end
        ST_RESP: begin
          // A real response takes precedence over a timeout in the same cycle.
          if (bus.mem_rvalid_i) begin
            if (r_owner_ls) begin
              r_ls_rvalid <= 1'b1;
              r_ls_rdata  <= bus.mem_rdata_i;
            end else begin
              r_if_rvalid <= 1'b1;
              r_if_rdata  <= bus.mem_rdata_i;
            end
            r_state <= ST_IDLE;
          end else if (w_timeout) begin
            if (r_owner_ls) begin
              r_ls_rvalid <= 1'b1;
              r_ls_err    <= 1'b1;
              r_ls_rdata  <= '0;
            end else begin
              r_if_rvalid <= 1'b1;
              r_if_err    <= 1'b1;
              r_if_rdata  <= '0;
            end
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.if_gnt_o    = w_if_gnt;
  assign bus.ls_gnt_o    = w_ls_gnt;
  assign bus.if_rvalid_o = r_if_rvalid;
  assign bus.if_err_o    = r_if_err;
  assign bus.if_rdata_o  = r_if_rdata;
  assign bus.ls_rvalid_o = r_ls_rvalid;
  assign bus.ls_err_o    = r_ls_err;
  assign bus.ls_rdata_o  = r_ls_rdata;
  assign bus.mem_req_o   = r_mem_req;
  assign bus.mem_we_o    = r_we;
  assign bus.mem_be_o    = r_be;
  assign bus.mem_addr_o  = r_addr;
  assign bus.mem_wdata_o = r_wdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed cases then randomized traffic
// against a transaction-level model of grant order, memory fields and responses.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned MAX_WAIT = 15;
  localparam int unsigned BE_W     = DATA_W / 8;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct {
    logic              ls;
    logic              we;
    logic [BE_W-1:0]   be;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mtx_t;

  typedef struct {
    logic              ls;
    logic              err;
    logic [DATA_W-1:0] data;
    int                cyc;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  mtx_t q_mem[$];
  rsp_t q_rsp[$];
  int   midx = 0;
  int   ridx = 0;
  int   mem_rd = 0;
  bit   busy = 1'b0;
  bit   last_ls = 1'b0;

  bit          plan_on = 1'b0;
  int          plan_gd = 0;
  int          plan_d = 0;
  logic [31:0] plan_data = '0;
  bit          noise_force = 1'b0;
  bit          noise_en = 1'b0;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops expected responses/transactions and compares every cycle.
  always @(negedge clk) begin
    rsp_t r;
    mtx_t m;
    bit ev, eg_if, eg_ls;
    logic [3:0] ev_bits;
    if (rst) begin
      busy = 1'b0;
      last_ls = 1'b0;
      midx = q_mem.size();
      ridx = q_rsp.size();
      chk("reset_ctrl", {bus.if_gnt_o, bus.ls_gnt_o, bus.if_rvalid_o, bus.if_err_o,
                         bus.ls_rvalid_o, bus.ls_err_o, bus.mem_req_o, bus.mem_we_o,
                         bus.mem_be_o, bus.mem_addr_o, bus.mem_wdata_o}, '0);
      chk("reset_rdata", {bus.if_rdata_o, bus.ls_rdata_o}, '0);
    end else begin
      ev = (ridx < q_rsp.size()) && (q_rsp[ridx].cyc == cyc);
      ev_bits = 4'b0;
      if (ev) begin
        r = q_rsp[ridx];
        ridx++;
        busy = 1'b0;
        ev_bits = r.ls ? {2'b00, 1'b1, r.err} : {1'b1, r.err, 2'b00};
      end
      chk("rvalid_err", {bus.if_rvalid_o, bus.if_err_o, bus.ls_rvalid_o, bus.ls_err_o}, ev_bits);
      if (ev && r.ls)  chk("ls_rdata", bus.ls_rdata_o, r.data);
      if (ev && !r.ls) chk("if_rdata", bus.if_rdata_o, r.data);

      chk("mem_req", bus.mem_req_o, midx < q_mem.size());
      if (bus.mem_req_o && midx < q_mem.size()) begin
        m = q_mem[midx];
        chk("mem_fields", {bus.mem_we_o, bus.mem_be_o, bus.mem_addr_o, bus.mem_wdata_o},
                          {m.we, m.be, m.addr, m.wdata});
        if (bus.mem_gnt_i) midx++;
      end

      eg_if = 1'b0;
      eg_ls = 1'b0;
      if (!busy) begin
        if (bus.ls_req_i && bus.if_req_i) eg_ls = RR ? !last_ls : 1'b1;
        else                              eg_ls = bus.ls_req_i;
        eg_if = bus.if_req_i && !eg_ls;
      end
      chk("gnt", {bus.if_gnt_o, bus.ls_gnt_o}, {eg_if, eg_ls});
      if (eg_if || eg_ls) begin
        m.ls    = eg_ls;
        m.we    = eg_ls ? bus.ls_we_i : 1'b0;
        m.be    = eg_ls ? bus.ls_be_i : '1;
        m.addr  = eg_ls ? bus.ls_addr_i : bus.if_addr_i;
        m.wdata = eg_ls ? bus.ls_wdata_i : '0;
        q_mem.push_back(m);
        busy = 1'b1;
        last_ls = eg_ls;
      end
    end
  end

  // Memory slave model: grant delay and response delay per transaction; pushes expected responses.
  initial begin : memory
    bit   resp;
    int   wcnt, gd, d, k;
    mtx_t m;
    rsp_t r;
    resp = 1'b0; wcnt = 0; gd = 0; d = 0; k = 0;
    bus.mem_gnt_i = 1'b0;
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.mem_gnt_i = 1'b0;
      bus.mem_rvalid_i = 1'b0;
      if (rst) begin
        resp = 1'b0;
        wcnt = 0;
        mem_rd = q_mem.size();
      end else if (resp) begin
        if (k == d) begin
          bus.mem_rvalid_i = 1'b1;
          bus.mem_rdata_i = plan_on ? plan_data : $urandom;
          r.ls = m.ls; r.err = 1'b0; r.data = bus.mem_rdata_i; r.cyc = cyc + 1;
          q_rsp.push_back(r);
          resp = 1'b0;
        end else if (k == int'(MAX_WAIT)) begin
          r.ls = m.ls; r.err = 1'b1; r.data = '0; r.cyc = cyc + 1;
          q_rsp.push_back(r);
          resp = 1'b0;
        end
        k++;
      end else begin
        bus.mem_rvalid_i = noise_force || (noise_en && $urandom_range(0, 3) == 0);
        bus.mem_rdata_i = $urandom;
        if (bus.mem_req_o && mem_rd < q_mem.size()) begin
          if (wcnt == 0) gd = plan_on ? plan_gd : int'($urandom_range(0, 3));
          if (wcnt == gd) begin
            bus.mem_gnt_i = 1'b1;
            m = q_mem[mem_rd];
            mem_rd++;
            wcnt = 0;
            resp = 1'b1;
            k = 0;
            if (plan_on)                      d = plan_d;
            else if ($urandom_range(0, 9) == 0) d = int'($urandom_range(MAX_WAIT - 1, MAX_WAIT + 3));
            else                              d = int'($urandom_range(0, 3));
          end else begin
            wcnt++;
          end
        end
      end
    end
  end

  // One requester cycle: sample grants, then drop any request that was just granted.
  task automatic step();
    logic gi, gl;
    @(negedge clk);
    gi = bus.if_gnt_o;
    gl = bus.ls_gnt_o;
    @(posedge clk);
    #2;
    if (bus.if_req_i && gi) bus.if_req_i = 1'b0;
    if (bus.ls_req_i && gl) bus.ls_req_i = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while ((bus.if_req_i || bus.ls_req_i || busy) && n < budget);
    if (bus.if_req_i || bus.ls_req_i || busy) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_idle: still busy after %0d cycles, want idle", budget);
    end
  endtask

  task automatic ls_op(input logic we, input logic [3:0] be, input logic [31:0] addr,
                       input logic [31:0] wdata);
    bus.ls_req_i = 1'b1;
    bus.ls_we_i = we;
    bus.ls_be_i = be;
    bus.ls_addr_i = addr;
    bus.ls_wdata_i = wdata;
  endtask

  task automatic set_plan(input int gd, input int d, input logic [31:0] data);
    plan_gd = gd;
    plan_d = d;
    plan_data = data;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    bus.if_req_i = 1'b0; bus.if_addr_i = '0;
    bus.ls_req_i = 1'b0; bus.ls_we_i = 1'b0; bus.ls_be_i = '0;
    bus.ls_addr_i = '0;  bus.ls_wdata_i = '0;
    repeat (3) step();
    rst = 1'b0;
    plan_on = 1'b1;

    set_plan(0, 0, 32'hDEADBEEF);
    bus.if_req_i = 1'b1;
    bus.if_addr_i = 32'h0000_0100;
    wait_idle(40);

    set_plan(2, 1, 32'h0);
    ls_op(1'b1, 4'h3, 32'h0000_0200, 32'h1234_5678);
    wait_idle(40);

    // Two ties in a row: second one exercises the tie-break history.
    set_plan(0, 0, 32'hA5A5_0001);
    for (int t = 0; t < 2; t++) begin
      bus.if_req_i = 1'b1;
      bus.if_addr_i = 32'h0000_0300 + 32'(t);
      ls_op(1'b0, 4'hF, 32'h0000_0400 + 32'(t), 32'h0);
      wait_idle(60);
    end

    set_plan(0, 100, 32'h0);
    ls_op(1'b0, 4'hF, 32'h0000_0500, 32'h0);
    wait_idle(60);

    set_plan(1, int'(MAX_WAIT), 32'hC0FF_EE00);
    ls_op(1'b0, 4'hC, 32'h0000_0600, 32'h0);
    wait_idle(60);

    // Reset while waiting in RESP, then a late response that must be ignored.
    set_plan(0, 100, 32'h0);
    bus.if_req_i = 1'b1;
    bus.if_addr_i = 32'h0000_0700;
    repeat (6) step();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    noise_force = 1'b1;
    step();
    noise_force = 1'b0;
    repeat (3) step();
    set_plan(0, 0, 32'h0BAD_F00D);
    bus.if_req_i = 1'b1;
    bus.if_addr_i = 32'h0000_0800;
    wait_idle(40);

    plan_on = 1'b0;
    noise_en = 1'b1;
    for (int c = 0; c < 2500; c++) begin
      step();
      if (!bus.if_req_i && $urandom_range(0, 2) == 0) begin
        bus.if_req_i = 1'b1;
        bus.if_addr_i = $urandom;
      end
      if (!bus.ls_req_i && $urandom_range(0, 2) == 0)
        ls_op(1'($urandom_range(0, 1)), 4'($urandom), $urandom, $urandom);
    end
    wait_idle(400);
    repeat (3) step();

    chk("drain_resp", 128'(ridx), 128'(q_rsp.size()));
    chk("drain_mem", 128'(midx), 128'(q_mem.size()));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
